ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_pkg.sv | 38 +++
 rtl/ps2_line_filter.sv | 53 +++++
 rtl/ps2_key_decoder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, frame FSM state type and pause-sequence lookup for the PS/2 key decoder.
// Revision 1.0
`default_nettype none

package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE_PREFIX = 8'hE1;
    localparam logic [7:0] PS2_PAUSE_CODE   = 8'h77;
    localparam int         PS2_PAUSE_LEN    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Pause key make/break: E1 14 77 E1 F0 14 F0 77
    function automatic logic [7:0] pause_seq_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = PS2_PAUSE_PREFIX;
            3'd1:    b = 8'h14;
            3'd2:    b = PS2_PAUSE_CODE;
            3'd3:    b = PS2_PAUSE_PREFIX;
            3'd4:    b = PS2_BRK_PREFIX;
            3'd5:    b = 8'h14;
            3'd6:    b = PS2_BRK_PREFIX;
            default: b = PS2_PAUSE_CODE;
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchronizers, PS/2 clock glitch filter and filtered falling-edge pulse.
// Revision 1.0
`default_nettype none

module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic sync_data,
    output logic fall_pulse
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             filt_q;
    logic [CNT_W-1:0] cnt_q;
    logic             fall_q;

    // The filtered level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            fall_q      <= 1'b0;
            if (clk_sync_q[1] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                cnt_q  <= '0;
                filt_q <= clk_sync_q[1];
                fall_q <= ~clk_sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign sync_data  = data_sync_q[1];
    assign fall_pulse = fall_q;

endmodule

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard frame receiver with E0/F0 prefix decode and timeout recovery.
// Optional macro PS2_PAUSE_SEQ_EN collapses the 8-byte Pause sequence into a single 0x177 key.
`default_nettype none

module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 42000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        rx_error,
    output logic        busy
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic sync_data;
    logic fall_pulse;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .sync_data  (sync_data),
        .fall_pulse (fall_pulse)
    );

    ps2_state_e       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic [9:0]       key_q, key_d;
    logic             strobe_q, strobe_d;
    logic             err_q, err_d;
`ifdef PS2_PAUSE_SEQ_EN
    logic [2:0]       pause_q, pause_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            key_q     <= '0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
`ifdef PS2_PAUSE_SEQ_EN
            pause_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tmo_q     <= tmo_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            key_q     <= key_d;
            strobe_q  <= strobe_d;
            err_q     <= err_d;
`ifdef PS2_PAUSE_SEQ_EN
            pause_q   <= pause_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tmo_d     = '0;
        ext_d     = ext_q;
        brk_d     = brk_q;
        key_d     = key_q;
        strobe_d  = 1'b0;
        err_d     = 1'b0;
`ifdef PS2_PAUSE_SEQ_EN
        pause_d   = pause_q;
`endif
        // Timeout wins over an edge landing in the same cycle.
        if (state_q != ST_IDLE && tmo_q == TMO_W'(TIMEOUT - 1)) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
`ifdef PS2_PAUSE_SEQ_EN
            pause_d = '0;
`endif
        end else begin
            if (state_q != ST_IDLE && !fall_pulse) begin
                tmo_d = tmo_q + 1'b1;
            end
            if (fall_pulse) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!sync_data) begin
                            state_d   = ST_DATA;
                            bit_cnt_d = '0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift_d   = {sync_data, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_d = sync_data;
                        state_d  = ST_STOP;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        if (!sync_data || !(^{shift_q, parity_q})) begin
                            err_d   = 1'b1;
                            ext_d   = 1'b0;
                            brk_d   = 1'b0;
`ifdef PS2_PAUSE_SEQ_EN
                            pause_d = '0;
                        end else if (pause_q != 3'd0) begin
                            if (shift_q != pause_seq_byte(pause_q)) begin
                                pause_d = '0;
                                ext_d   = 1'b0;
                                brk_d   = 1'b0;
                            end else if (pause_q == 3'(PS2_PAUSE_LEN - 1)) begin
                                pause_d  = '0;
                                key_d    = {2'b01, PS2_PAUSE_CODE};
                                strobe_d = 1'b1;
                                ext_d    = 1'b0;
                                brk_d    = 1'b0;
                            end else begin
                                pause_d = pause_q + 1'b1;
                            end
                        end else if (shift_q == PS2_PAUSE_PREFIX) begin
                            pause_d = 3'd1;
`else
                        end else if (shift_q == PS2_PAUSE_PREFIX) begin
                            ext_d = ext_q;
`endif
                        end else if (shift_q == PS2_EXT_PREFIX) begin
                            ext_d = 1'b1;
                        end else if (shift_q == PS2_BRK_PREFIX) begin
                            brk_d = 1'b1;
                        end else begin
                            key_d    = {brk_q, ext_q, shift_q};
                            strobe_d = 1'b1;
                            ext_d    = 1'b0;
                            brk_d    = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign ps2_key  = {strobe_q, key_q};
    assign rx_error = err_q;
`ifdef PS2_PAUSE_SEQ_EN
    assign busy = (state_q != ST_IDLE) || ext_q || brk_q || (pause_q != 3'd0);
`else
    assign busy = (state_q != ST_IDLE) || ext_q || brk_q;
`endif

endmodule

`default_nettype wire
